// File: rtl/serial_operand_feeder.sv
// serial_operand_feeder: accepts two parallel operands over valid/ready and
// streams them LSB-first as bit pairs, with framing strobes and a carry-clear
// pulse for a downstream serial adder.
// Optional feature macro: SERIAL_SUM_CAPTURE_EN (adds z_bit in / sum_out out,
// collecting the adder's serial sum back into a parallel word).
module serial_operand_feeder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             shift_en,
  output logic             x_bit,
  output logic             y_bit,
  output logic             bit_valid,
  output logic             first_bit,
  output logic             last_bit,
  output logic             carry_clr,
  output logic             busy,
  output logic             done
`ifdef SERIAL_SUM_CAPTURE_EN
  ,
  input  logic             z_bit,
  output logic [WIDTH-1:0] sum_out
`endif
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   sr_a;
  logic [WIDTH-1:0]   sr_b;
  logic [CNT_W-1:0]   cnt;
  logic               accept;
  logic               advance;
  logic               cnt_first;
  logic               cnt_last;

  assign cnt_first = (cnt == '0);
  assign cnt_last  = (cnt == CNT_W'(WIDTH - 1));

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and output decode; every output is forced low while reset is high
  always_comb begin
    state_nxt  = state;
    load_ready = 1'b0;
    x_bit      = 1'b0;
    y_bit      = 1'b0;
    bit_valid  = 1'b0;
    first_bit  = 1'b0;
    last_bit   = 1'b0;
    carry_clr  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    advance    = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          load_ready = 1'b1;
          if (load_valid) begin
            accept    = 1'b1;
            state_nxt = SHIFT;
          end
        end
        SHIFT: begin
          busy      = 1'b1;
          bit_valid = 1'b1;
          x_bit     = sr_a[0];
          y_bit     = sr_b[0];
          first_bit = cnt_first;
          last_bit  = cnt_last;
          carry_clr = cnt_first & shift_en;
          if (shift_en) begin
            advance = 1'b1;
            if (cnt_last) state_nxt = DONE;
          end
        end
        DONE: begin
          busy      = 1'b1;
          done      = 1'b1;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Operand shift registers and bit counter
  always_ff @(posedge clock) begin
    if (reset) begin
      sr_a <= '0;
      sr_b <= '0;
      cnt  <= '0;
    end else if (accept) begin
      sr_a <= a_in;
      sr_b <= b_in;
      cnt  <= '0;
    end else if (advance) begin
      sr_a <= {1'b0, sr_a[WIDTH-1:1]};
      sr_b <= {1'b0, sr_b[WIDTH-1:1]};
      cnt  <= cnt + CNT_W'(1);
    end
  end

`ifdef SERIAL_SUM_CAPTURE_EN
  // Serial sum collector: bits enter at the MSB so bit 0 ends up in sum_out[0]
  always_ff @(posedge clock) begin
    if (reset || accept) sum_out <= '0;
    else if (advance)    sum_out <= {z_bit, sum_out[WIDTH-1:1]};
  end
`endif

endmodule

// File: tb/tb_serial_operand_feeder.sv
// Scoreboard bench for serial_operand_feeder: the driver pushes the expected
// per-cycle stream into a queue and a negedge monitor pops and compares
// whenever the DUT shows bit_valid or done.
module tb_serial_operand_feeder;

  localparam int unsigned W = 8;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         load_valid = 1'b0;
  logic         load_ready;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         shift_en = 1'b1;
  logic         x_bit, y_bit, bit_valid, first_bit, last_bit, carry_clr, busy, done;

  int errors = 0;
  int checks = 0;

  // Observed tuple: bit_valid, x, y, first, last, carry_clr, done, load_ready, busy
  typedef struct packed {
    logic bv; logic x; logic y; logic first; logic last;
    logic cc; logic done; logic rdy; logic busy;
  } obs_t;

  obs_t exp_q[$];
  obs_t mon_act;
  obs_t mon_exp;

`ifdef SERIAL_SUM_CAPTURE_EN
  logic         z_bit;
  logic [W-1:0] sum_out;
  logic         carry;
  logic         cin;
  // Reference serial adder whose carry is cleared by carry_clr
  assign cin   = carry_clr ? 1'b0 : carry;
  assign z_bit = x_bit ^ y_bit ^ cin;
  always @(posedge clock) begin
    if (reset) carry <= 1'b0;
    else if (bit_valid && shift_en) carry <= (x_bit & y_bit) | (x_bit & cin) | (y_bit & cin);
  end
`endif

  serial_operand_feeder #(.WIDTH(W)) dut (
    .clock      (clock),
    .reset      (reset),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .a_in       (a_in),
    .b_in       (b_in),
    .shift_en   (shift_en),
    .x_bit      (x_bit),
    .y_bit      (y_bit),
    .bit_valid  (bit_valid),
    .first_bit  (first_bit),
    .last_bit   (last_bit),
    .carry_clr  (carry_clr),
    .busy       (busy),
    .done       (done)
`ifdef SERIAL_SUM_CAPTURE_EN
    ,
    .z_bit      (z_bit),
    .sum_out    (sum_out)
`endif
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every cycle with a valid bit or done must match the next queued entry
  always @(negedge clock) begin
    if (bit_valid || done) begin
      mon_act = {bit_valid, x_bit, y_bit, first_bit, last_bit, carry_clr, done, load_ready, busy};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got %09b expected nothing", mon_act);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) begin
          errors++;
          $display("FAIL stream(bv,x,y,first,last,cc,done,rdy,busy) at %0t: got %09b expected %09b",
                   $time, mon_act, mon_exp);
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clock);
    while (!load_ready && n < 40) begin
      @(negedge clock);
      n++;
    end
    check1("wait_load_ready", 32'(load_ready), 32'd1);
  endtask

  function automatic bit se_at(input int c, input int stall_at, input int stall_len);
    return !(c >= stall_at && c < stall_at + stall_len);
  endfunction

  // Send one word; shift_en is low for cycles [stall_at, stall_at+stall_len)
  task automatic send_word(input logic [W-1:0] a, input logic [W-1:0] b,
                           input int stall_at, input int stall_len, input bit junk);
    int   i;
    int   ncyc;
    bit   se;
    obs_t e;
    wait_ready();
    a_in = a;
    b_in = b;
    load_valid = 1'b1;
    i = 0;
    ncyc = 0;
    while (i < int'(W)) begin
      ncyc++;
      se = se_at(ncyc, stall_at, stall_len);
      e = {1'b1, a[i], b[i], 1'(i == 0), 1'(i == int'(W) - 1), 1'((i == 0) && se), 1'b0, 1'b0, 1'b1};
      exp_q.push_back(e);
      if (se) i++;
    end
    exp_q.push_back({1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1});
    @(posedge clock); #1;
    load_valid = junk;
    if (junk) a_in = 8'h33;
    for (int c = 1; c <= ncyc; c++) begin
      shift_en = se_at(c, stall_at, stall_len);
      @(posedge clock); #1;
    end
    shift_en = 1'b1;
`ifdef SERIAL_SUM_CAPTURE_EN
    begin
      logic [W-1:0] s;
      s = a + b;
      @(negedge clock);
      check1("sum_out_at_done", 32'(sum_out), 32'(s));
    end
`endif
    @(posedge clock); #1;
    load_valid = 1'b0;
    @(negedge clock);
    check1("ready_after_done", 32'({load_ready, busy}), 32'(2'b10));
  endtask

  initial begin
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check1("outputs_in_reset", 32'({load_ready, busy, bit_valid, done, x_bit, y_bit, carry_clr}), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check1("ready_first_cycle_after_reset", 32'({load_ready, busy}), 32'(2'b10));

    send_word(8'hAA, 8'h55, 0, 0, 1'b0);
    send_word(8'h0F, 8'hFF, 3, 3, 1'b0);
    send_word(8'hC3, 8'h96, 0, 0, 1'b1);

    // Reset asserted in cycle 4 of a word: bits 0..2 seen, then stream aborts
    wait_ready();
    a_in = 8'h5A;
    b_in = 8'h3C;
    load_valid = 1'b1;
    exp_q.push_back({1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1});
    exp_q.push_back({1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    exp_q.push_back({1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    @(posedge clock); #1;
    load_valid = 1'b0;
    repeat (3) begin
      @(posedge clock); #1;
    end
    reset = 1'b1;
    @(negedge clock);
    check1("outputs_during_midword_reset", 32'({bit_valid, busy, load_ready, done}), 32'(4'b0000));
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check1("after_midword_reset", 32'({bit_valid, busy, load_ready, done}), 32'(4'b0010));
    repeat (12) @(negedge clock);

`ifdef SERIAL_SUM_CAPTURE_EN
    send_word(8'd100, 8'd27, 0, 0, 1'b0);
    send_word(8'hFF, 8'h01, 0, 0, 1'b0);
`endif

    send_word(8'h01, 8'h80, 0, 0, 1'b0);

    repeat (3) @(negedge clock);
    check1("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_operand_feeder.md
Name: serial_operand_feeder

Overview:
- Front-end stage for the serial adder.
- Accepts two WIDTH-bit parallel operands through a valid/ready handshake, then presents them LSB-first, one bit pair per clock, on x_bit/y_bit.
- Generates framing strobes (first/last/done) and a carry-clear pulse so the adder's carry flop starts each word at zero.
- Optionally collects the adder's serial sum back into a parallel word.

Parameters:
- WIDTH, 8, operand width in bits (≥2); the bit counter is $clog2(WIDTH) bits wide.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- load_valid  in  1  operands a_in/b_in are presented
- load_ready  out  1  feeder can accept operands
- a_in  in  WIDTH  operand A (drives x stream)
- b_in  in  WIDTH  operand B (drives y stream)
- shift_en  in  1  downstream advance enable; 0 stalls the stream
- x_bit  out  1  current bit of A
- y_bit  out  1  current bit of B
- bit_valid  out  1  x_bit/y_bit are valid this cycle
- first_bit  out  1  current bit is bit 0
- last_bit  out  1  current bit is bit WIDTH-1
- carry_clr  out  1  clear adder carry; equals first_bit & shift_en
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse after the last bit is consumed

Behaviour:
- Clock and reset: one clock, `clock`. Reset `reset` is synchronous and active-high, sampled on the rising edge.
- Reset values:
  - state = IDLE; shift registers = 0; counter = 0.
  - All outputs are 0 while reset is high, including load_ready.
  - load_ready rises in the first cycle after reset is released.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - load_ready = 1; bit_valid = 0; x_bit = y_bit = 0.
  - On load_valid & load_ready: sr_a ← a_in, sr_b ← b_in, cnt ← 0, state → SHIFT.
- SHIFT:
  - bit_valid = 1; x_bit = sr_a[0]; y_bit = sr_b[0]; load_ready = 0.
  - first_bit = (cnt == 0); last_bit = (cnt == WIDTH-1).
  - When shift_en = 1: shift both registers right by one (MSB filled with 0) and cnt ← cnt+1. If last_bit, state → DONE.
  - When shift_en = 0: registers, cnt and outputs hold (stall). carry_clr stays 0 while stalled.
- DONE:
  - done = 1 for exactly one cycle; bit_valid = 0.
  - state → IDLE unconditionally.
  - load_valid is ignored here; no back-to-back accept.
- Latency, with shift_en held at 1:
  - Accept edge at cycle 0.
  - Bit 0 is valid in cycle 1; bit WIDTH-1 is valid in cycle WIDTH.
  - done is high in cycle WIDTH+1.
  - load_ready is high again in cycle WIDTH+2.
- Operand capture: a_in and b_in are sampled only on the accept edge. Later changes to them do not affect the word in flight.
- load_valid during SHIFT or DONE: ignored. The new operands are not queued.
- Reset mid-word: the stream is aborted immediately and the FSM returns to IDLE. No done pulse is emitted.
- No arithmetic is performed in this block; the bit order is strictly LSB-first.

Optional Feature:
- Macro: SERIAL_SUM_CAPTURE_EN.
- Defined:
  - Adds port z_bit (in, 1): the adder's sum bit for the current bit pair.
  - Adds port sum_out (out, WIDTH).
  - In SHIFT with shift_en = 1, z_bit is shifted into sum_out from the MSB (sum_out ← {z_bit, sum_out[WIDTH-1:1]}). After WIDTH bits, sum_out[0] holds the bit-0 sum.
  - sum_out is stable and valid from the DONE cycle until the next accept.
  - sum_out is cleared by reset and on each accept edge.
- Undefined: the z_bit and sum_out ports and their logic do not exist; all other behaviour is identical.

Test Plan:
- Single word, WIDTH=8, a_in=8'hAA, b_in=8'h55, shift_en=1:
  - x_bit = 0,1,0,1,0,1,0,1 and y_bit = 1,0,1,0,1,0,1,0 over cycles 1–8.
  - first_bit and carry_clr in cycle 1 only; last_bit in cycle 8.
  - done in cycle 9; load_ready=1 in cycle 10.
- Stall: a_in=8'h0F, b_in=8'hFF, shift_en=0 for cycles 3–5:
  - x_bit/y_bit and cnt frozen at bit 2 for those cycles.
  - done is delayed by 3 cycles, to cycle 12.
- Ignored load: load_valid=1 with a_in=8'h33 during SHIFT of word 8'hC3:
  - The stream still emits 8'hC3 bits; load_ready stays 0 until IDLE.
- Reset mid-word: assert reset in cycle 4 of a word:
  - Next cycle: bit_valid=0, busy=0, and done is never pulsed.
  - load_ready=1 in the first cycle after reset drops.
- With SERIAL_SUM_CAPTURE_EN: a_in=8'd100, b_in=8'd27, z_bit driven by a serial adder model using carry_clr:
  - sum_out = 8'd127 at done.
  - Second word a_in=8'hFF, b_in=8'h01 gives sum_out = 8'h00 (carry dropped).
